// File: rtl/render_pkg.sv
// Shared screen constants, colour/entry types and sink FSM encoding for the tile-render output path.
package render_pkg;

  localparam int SCREEN_X_MAX    = 1079;
  localparam int SCREEN_Y_MAX    = 2159;
  localparam int COORD_X_W       = 11;
  localparam int COORD_Y_W       = 12;
  localparam int PIX_CNT_W       = 22;
  localparam int SINK_FIFO_DEPTH = 16;

  typedef logic [31:0] argb_t;

  typedef struct packed {
    logic  sof;
    logic  eof;
    argb_t data;
  } pix_entry_t;

  localparam int ENTRY_W = $bits(pix_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } sink_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage is not reset; the head is only meaningful while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/pixel_stream_sink.sv
// Pixel stream sink: buffers raster pixels, re-emits them with sof/eof tags and tracks frame state.
// Build option PIXEL_SINK_ORDER_CHECK_EN adds the raster-order comparator behind order_err.
module pixel_stream_sink
  import render_pkg::*;
#(
  parameter int X_MAX      = SCREEN_X_MAX,
  parameter int Y_MAX      = SCREEN_Y_MAX,
  parameter int FIFO_DEPTH = SINK_FIFO_DEPTH,
  parameter int X_W        = COORD_X_W,
  parameter int Y_W        = COORD_Y_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [X_W-1:0]                in_x,
  input  logic [Y_W-1:0]                in_y,
  input  logic [31:0]                   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic                          out_sof,
  output logic                          out_eof,
  output logic                          frame_done,
  output logic                          order_err,
  output logic                          overflow,
  output logic [PIX_CNT_W-1:0]          pix_count,
  output sink_state_e                   dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_fill
);

  sink_state_e          state_q, state_d;
  logic [PIX_CNT_W-1:0] pix_count_q, pix_count_d;
  logic                 overflow_q, overflow_d;
  logic                 frame_done_q, frame_done_d;

  pix_entry_t wr_entry;
  pix_entry_t head;
  logic       fifo_full, fifo_empty;
  logic       want, push, pop;
  logic       in_sof, in_eof;

  assign in_sof   = (in_x == '0) && (in_y == '0);
  assign in_eof   = (in_x == X_W'(X_MAX)) && (in_y == Y_W'(Y_MAX));
  assign pop      = !fifo_empty && out_ready;
  assign wr_entry = '{sof: in_sof, eof: in_eof, data: in_data};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (dbg_fill)
  );

  // The FSM only advances on pixels that actually enter the FIFO, so a dropped eof cannot strand DRAIN.
  always_comb begin
    state_d      = state_q;
    pix_count_d  = pix_count_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    want         = 1'b0;
    push         = 1'b0;
    case (state_q)
      ST_IDLE:   want = in_valid && in_sof;
      ST_STREAM: want = in_valid;
      default:   want = 1'b0;
    endcase
    push = want && (!fifo_full || pop);
    if (want && !push) overflow_d = 1'b1;
    if (push) begin
      pix_count_d = in_sof ? PIX_CNT_W'(1) : pix_count_q + PIX_CNT_W'(1);
      state_d     = in_eof ? ST_DRAIN : ST_STREAM;
    end
    if (state_q == ST_DRAIN && pop && head.eof) begin
      state_d      = ST_IDLE;
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pix_count_q  <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_count_q  <= pix_count_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef PIXEL_SINK_ORDER_CHECK_EN
  logic [X_W-1:0] exp_x_q, exp_x_d;
  logic [Y_W-1:0] exp_y_q, exp_y_d;
  logic           order_err_q, order_err_d;

  // Expectation always re-derives from the received coordinate, so one glitch flags once and resyncs.
  always_comb begin
    exp_x_d     = exp_x_q;
    exp_y_d     = exp_y_q;
    order_err_d = order_err_q;
    if (push) begin
      if (in_sof) begin
        if (state_q == ST_STREAM) order_err_d = 1'b1;
      end else if (in_x != exp_x_q || in_y != exp_y_q) begin
        order_err_d = 1'b1;
      end
      if (in_y == Y_W'(Y_MAX)) begin
        exp_x_d = in_x + X_W'(1);
        exp_y_d = '0;
      end else begin
        exp_x_d = in_x;
        exp_y_d = in_y + Y_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_x_q     <= '0;
      exp_y_q     <= '0;
      order_err_q <= 1'b0;
    end else begin
      exp_x_q     <= exp_x_d;
      exp_y_q     <= exp_y_d;
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

  // valid/ready: the head entry transfers on any clock edge where out_valid && out_ready.
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : head.data;
  assign out_sof    = !fifo_empty && head.sof;
  assign out_eof    = !fifo_empty && head.eof;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign pix_count  = pix_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Directed bench for pixel_stream_sink on a shrunken 4x5 screen so whole frames fit in a short run.
module tb_pixel_stream_sink;
  import render_pkg::*;

  localparam int XM    = 3;
  localparam int YM    = 4;
  localparam int DEPTH = 16;
  localparam int XW    = 11;
  localparam int YW    = 12;
  localparam int NPIX  = (XM + 1) * (YM + 1);
`ifdef PIXEL_SINK_ORDER_CHECK_EN
  localparam logic ORD = 1'b1;
`else
  localparam logic ORD = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [XW-1:0]        in_x = '0;
  logic [YW-1:0]        in_y = '0;
  logic [31:0]          in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [31:0]          out_data;
  logic                 out_sof, out_eof, frame_done, order_err, overflow;
  logic [PIX_CNT_W-1:0] pix_count;
  sink_state_e          dbg_state;
  logic [$clog2(DEPTH):0] dbg_fill;

  int total = 0;
  int bad   = 0;

  pixel_stream_sink #(
    .X_MAX(XM), .Y_MAX(YM), .FIFO_DEPTH(DEPTH), .X_W(XW), .Y_W(YW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .frame_done(frame_done), .order_err(order_err), .overflow(overflow),
    .pix_count(pix_count), .dbg_state(dbg_state), .dbg_fill(dbg_fill)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pdata(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic send_xy(input int x, input int y, input logic [31:0] d);
    in_valid = 1'b1;
    in_x     = XW'(x);
    in_y     = YW'(y);
    in_data  = d;
  endtask

  task automatic send(input int i);
    send_xy(i / (YM + 1), i % (YM + 1), pdata(i));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_sof"}, 32'(out_sof), 32'd0);
    chk({tag, "_eof"}, 32'(out_eof), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_oerr"}, 32'(order_err), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_cnt"}, 32'(pix_count), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({tag, "_fill"}, 32'(dbg_fill), 32'd0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk_cleared("rst");
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // Power-on reset
    out_ready = 1'b1;
    do_reset();

    // Pre-frame junk is dropped in IDLE without raising order_err
    send_xy(5, 7, 32'h1111_1111);
    tick();
    chk("junk1_valid", 32'(out_valid), 32'd0);
    chk("junk1_state", 32'(dbg_state), 32'(ST_IDLE));
    send_xy(5, 8, 32'h2222_2222);
    tick();
    chk("junk2_valid", 32'(out_valid), 32'd0);
    chk("junk2_oerr", 32'(order_err), 32'd0);
    chk("junk2_cnt", 32'(pix_count), 32'd0);

    // Full frame with downstream always ready
    for (int i = 0; i < NPIX; i++) begin
      send(i);
      tick();
      chk("frm_valid", 32'(out_valid), 32'd1);
      chk("frm_data", out_data, pdata(i));
      chk("frm_sof", 32'(out_sof), (i == 0) ? 32'd1 : 32'd0);
      chk("frm_eof", 32'(out_eof), (i == NPIX - 1) ? 32'd1 : 32'd0);
      chk("frm_cnt", 32'(pix_count), 32'(i + 1));
      chk("frm_fill", 32'(dbg_fill), 32'd1);
      chk("frm_done", 32'(frame_done), 32'd0);
      chk("frm_state", 32'(dbg_state), (i == NPIX - 1) ? 32'(ST_DRAIN) : 32'(ST_STREAM));
    end
    // An sof while draining is ignored; eof pops on this edge
    send_xy(0, 0, 32'hDEAD_BEEF);
    tick();
    chk("eofpop_done", 32'(frame_done), 32'd1);
    chk("eofpop_valid", 32'(out_valid), 32'd0);
    chk("eofpop_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("eofpop_cnt", 32'(pix_count), 32'(NPIX));
    idle();
    tick();
    chk("post_done", 32'(frame_done), 32'd0);
    chk("post_cnt", 32'(pix_count), 32'(NPIX));
    chk("post_oerr", 32'(order_err), 32'd0);
    chk("post_ovf", 32'(overflow), 32'd0);

    // Backpressure: fill, push+pop while full, then drop on full
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send(i);
      tick();
    end
    chk("bp_fill", 32'(dbg_fill), 32'(DEPTH));
    chk("bp_head", out_data, pdata(0));
    chk("bp_sof", 32'(out_sof), 32'd1);
    chk("bp_ovf0", 32'(overflow), 32'd0);
    chk("bp_cnt16", 32'(pix_count), 32'(DEPTH));
    out_ready = 1'b1;
    send(DEPTH);
    tick();
    chk("pp_fill", 32'(dbg_fill), 32'(DEPTH));
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_cnt", 32'(pix_count), 32'(DEPTH + 1));
    chk("pp_head", out_data, pdata(1));
    out_ready = 1'b0;
    send(DEPTH + 1);
    tick();
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_cnt", 32'(pix_count), 32'(DEPTH + 1));
    chk("drop_fill", 32'(dbg_fill), 32'(DEPTH));
    chk("drop_head", out_data, pdata(1));
    idle();
    out_ready = 1'b1;
    for (int k = 2; k <= DEPTH; k++) begin
      tick();
      chk("drain_data", out_data, pdata(k));
    end
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_state", 32'(dbg_state), 32'(ST_STREAM));
    chk("drain_ovf", 32'(overflow), 32'd1);

    // Restart mid-STREAM, then reset with 5 entries held
    out_ready = 1'b0;
    send_xy(0, 0, 32'hAAAA_0000);
    tick();
    chk("rs_cnt", 32'(pix_count), 32'd1);
    chk("rs_oerr", 32'(order_err), 32'(ORD));
    chk("rs_state", 32'(dbg_state), 32'(ST_STREAM));
    for (int y = 1; y <= 4; y++) begin
      send_xy(0, y, 32'hAAAA_0000 | 32'(y));
      tick();
    end
    chk("rs_cnt5", 32'(pix_count), 32'd5);
    chk("rs_fill5", 32'(dbg_fill), 32'd5);
    chk("rs_head", out_data, 32'hAAAA_0000);
    idle();
    rst_n = 1'b0;
    #1;
    chk_cleared("async");
    tick();
    rst_n = 1'b1;
    tick();

    // Raster-order break: after (0,YM) send (2,0), then the resynced (2,1)
    out_ready = 1'b1;
    for (int y = 0; y <= YM; y++) begin
      send_xy(0, y, 32'hB000_0000 | 32'(y));
      tick();
    end
    chk("ord_clean", 32'(order_err), 32'd0);
    send_xy(2, 0, 32'hB000_0020);
    tick();
    chk("ord_err", 32'(order_err), 32'(ORD));
    chk("ord_cnt", 32'(pix_count), 32'(YM + 2));
    send_xy(2, 1, 32'hB000_0021);
    tick();
    chk("ord_resync", 32'(order_err), 32'(ORD));
    chk("ord_data", out_data, 32'hB000_0021);
    chk("ord_ovf", 32'(overflow), 32'd0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
